search_table_requester: RTL and testbench

- Initiator/client for the search-table lookup and maintenance interface.
- Accepts commands from an upstream valid/ready port and serialises them onto the table's req/search and opReq/opCode/opSearch/opResult pins.
- Waits for the table's completion or applies a fixed completion window, then returns found/result/error on a downstream valid/ready port.
- Sits between control logic (packet classifier, host register bank) and the table.

---
 rtl/search_table_pkg.sv | 40 ++++
 rtl/req_window_timer.sv | 29 ++
 rtl/search_table_requester.sv | 204 ++++++++++++++++++++
 tb/tb_search_table_requester.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/search_table_pkg.sv
// Shared encodings for the search-table requester: upstream command ops,
// table opcodes, FSM states and the command-to-opcode mapping.
package search_table_pkg;

    typedef enum logic [2:0] {
        CMD_LOOKUP = 3'd0,
        CMD_ADD    = 3'd1,
        CMD_DELETE = 3'd2,
        CMD_UPDATE = 3'd3,
        CMD_CLEAR  = 3'd4
    } cmdOpT;

    typedef enum logic [1:0] {
        TBL_ADD    = 2'b00,
        TBL_DELETE = 2'b01,
        TBL_UPDATE = 2'b10,
        TBL_CLEAR  = 2'b11
    } tblOpT;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_ISSUE,
        ST_RESP
    } stateT;

    function automatic logic isLegalOp(input logic [2:0] op);
        return (op <= CMD_CLEAR);
    endfunction

    function automatic tblOpT toTblOp(input logic [2:0] op);
        case (op)
            CMD_DELETE: return TBL_DELETE;
            CMD_UPDATE: return TBL_UPDATE;
            CMD_CLEAR:  return TBL_CLEAR;
            default:    return TBL_ADD;
        endcase
    endfunction

endpackage

// File: rtl/req_window_timer.sv
// Loadable down-counter used for both the grant-wait timeout and the
// request window. expired is high while the count sits at zero.
module req_window_timer #(
    parameter int MAX_COUNT = 64,
    localparam int W = $clog2(MAX_COUNT + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] loadVal,
    output logic         expired
);

    logic [W-1:0] count;

    // load takes priority; otherwise count down and hold at zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/search_table_requester.sv
// Requester that serialises upstream commands onto the search-table
// lookup/maintenance pins and returns a response per command.
// Optional macro SEARCH_TABLE_REQ_STATS_EN adds saturating response counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | cmd_ready high, waiting for a command
// ST_GRANT | waiting for rdy/opRdy, bounded by GRANT_TIMEOUT
// ST_ISSUE | req or opReq driven for the window (plus one opErr tail cycle)
// ST_RESP  | response held until rsp_ready
module search_table_requester
    import search_table_pkg::*;
#(
    parameter int KEY_W         = 48,
    parameter int DATA_W        = 16,
    parameter int LOOKUP_CYCLES = 4,
    parameter int OP_CYCLES     = 4,
    parameter int GRANT_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [KEY_W-1:0]  cmd_key,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              req,
    output logic [KEY_W-1:0]  search,
    output logic              opReq,
    output logic [1:0]        opCode,
    output logic [KEY_W-1:0]  opSearch,
    output logic [DATA_W-1:0] opResult,
    input  logic              rdy,
    input  logic              opRdy,
    input  logic              found,
    input  logic              done,
    input  logic [DATA_W-1:0] result,
    input  logic              opErr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_found,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [DATA_W-1:0] rsp_data
`ifdef SEARCH_TABLE_REQ_STATS_EN
    ,
    output logic [15:0]       stat_lookups,
    output logic [15:0]       stat_hits,
    output logic [15:0]       stat_errors
`endif
);

    localparam int TW = $clog2(GRANT_TIMEOUT + 1);

    stateT             state, stateNext;
    logic              armed;
    logic [2:0]        opQ;
    logic [KEY_W-1:0]  keyQ;
    logic [DATA_W-1:0] dataQ;
    logic              opTail, opErrAcc;
    logic              rspFoundQ, rspErrQ, rspTimeoutQ;
    logic [DATA_W-1:0] rspDataQ;
    logic              tmrLoad, tmrExpired;
    logic [TW-1:0]     tmrLoadVal;
    logic              accept, isLookup, granted;

    assign accept   = cmd_valid && cmd_ready;
    assign isLookup = (opQ == CMD_LOOKUP);
    assign granted  = isLookup ? rdy : opRdy;

    req_window_timer #(.MAX_COUNT(GRANT_TIMEOUT)) uTimer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmrLoad),
        .loadVal (tmrLoadVal),
        .expired (tmrExpired)
    );

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= stateNext;
    end

    // next-state and timer reload; the timer counts the cycles left in GRANT or ISSUE
    always_comb begin
        stateNext  = state;
        tmrLoad    = 1'b0;
        tmrLoadVal = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (isLegalOp(cmd_op)) begin
                        stateNext  = ST_GRANT;
                        tmrLoad    = 1'b1;
                        tmrLoadVal = TW'(GRANT_TIMEOUT - 1);
                    end else begin
                        stateNext = ST_RESP;
                    end
                end
            end
            ST_GRANT: begin
                if (granted) begin
                    stateNext  = ST_ISSUE;
                    tmrLoad    = 1'b1;
                    tmrLoadVal = isLookup ? TW'(LOOKUP_CYCLES - 1) : TW'(OP_CYCLES - 1);
                end else if (tmrExpired) begin
                    stateNext = ST_RESP;
                end
            end
            ST_ISSUE: begin
                if (isLookup) begin
                    if (done || tmrExpired) stateNext = ST_RESP;
                end else if (opTail) begin
                    stateNext = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) stateNext = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // outputs decoded from state; table pins are zero whenever no request is active
    always_comb begin
        cmd_ready   = (state == ST_IDLE) && armed;
        req         = (state == ST_ISSUE) && isLookup;
        opReq       = (state == ST_ISSUE) && !isLookup && !opTail;
        search      = req ? keyQ : '0;
        opCode      = opReq ? toTblOp(opQ) : TBL_ADD;
        opSearch    = (opReq && opQ != CMD_CLEAR) ? keyQ : '0;
        opResult    = (opReq && opQ != CMD_CLEAR) ? dataQ : '0;
        rsp_valid   = (state == ST_RESP);
        rsp_found   = rsp_valid && rspFoundQ;
        rsp_err     = rsp_valid && rspErrQ;
        rsp_timeout = rsp_valid && rspTimeoutQ;
        rsp_data    = rsp_valid ? rspDataQ : '0;
    end

    // command capture and response accumulation; table inputs only sampled in ISSUE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed       <= 1'b0;
            opQ         <= '0;
            keyQ        <= '0;
            dataQ       <= '0;
            opTail      <= 1'b0;
            opErrAcc    <= 1'b0;
            rspFoundQ   <= 1'b0;
            rspErrQ     <= 1'b0;
            rspTimeoutQ <= 1'b0;
            rspDataQ    <= '0;
        end else begin
            armed <= 1'b1;
            if (accept) begin
                opQ         <= cmd_op;
                keyQ        <= cmd_key;
                dataQ       <= cmd_data;
                opTail      <= 1'b0;
                opErrAcc    <= 1'b0;
                rspFoundQ   <= 1'b0;
                rspDataQ    <= '0;
                rspTimeoutQ <= 1'b0;
                rspErrQ     <= !isLegalOp(cmd_op);
            end
            if (state == ST_GRANT && !granted && tmrExpired) begin
                rspErrQ     <= 1'b1;
                rspTimeoutQ <= 1'b1;
            end
            if (state == ST_ISSUE) begin
                if (isLookup) begin
                    if (done) begin
                        rspFoundQ <= found;
                        rspDataQ  <= found ? result : '0;
                    end
                end else begin
                    opErrAcc <= opErrAcc | opErr;
                    if (tmrExpired) opTail <= 1'b1;
                    if (opTail)     rspErrQ <= opErrAcc | opErr;
                end
            end
        end
    end

`ifdef SEARCH_TABLE_REQ_STATS_EN
    // saturating counters bumped on each consumed response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_lookups <= '0;
            stat_hits    <= '0;
            stat_errors  <= '0;
        end else if (rsp_valid && rsp_ready) begin
            if (isLookup && !rspErrQ && stat_lookups != '1) stat_lookups <= stat_lookups + 16'd1;
            if (rsp_found && stat_hits != '1)               stat_hits    <= stat_hits + 16'd1;
            if (rsp_err && stat_errors != '1)               stat_errors  <= stat_errors + 16'd1;
        end
    end
`endif

    // the table must never see both request types at once
    assert property (@(posedge clk) disable iff (!reset) !(req && opReq));

endmodule

// File: tb/tb_search_table_requester.sv
module tb_search_table_requester;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_op;
    logic [47:0] cmd_key;
    logic [15:0] cmd_data;
    logic        req, opReq;
    logic [47:0] search, opSearch;
    logic [1:0]  opCode;
    logic [15:0] opResult;
    logic        rdy, opRdy, found, done, opErr;
    logic [15:0] result;
    logic        rsp_valid, rsp_ready, rsp_found, rsp_err, rsp_timeout;
    logic [15:0] rsp_data;
`ifdef SEARCH_TABLE_REQ_STATS_EN
    logic [15:0] stat_lookups, stat_hits, stat_errors;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    search_table_requester dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_key(cmd_key), .cmd_data(cmd_data),
        .req(req), .search(search), .opReq(opReq), .opCode(opCode),
        .opSearch(opSearch), .opResult(opResult),
        .rdy(rdy), .opRdy(opRdy), .found(found), .done(done),
        .result(result), .opErr(opErr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_found(rsp_found),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .rsp_data(rsp_data)
`ifdef SEARCH_TABLE_REQ_STATS_EN
        , .stat_lookups(stat_lookups), .stat_hits(stat_hits), .stat_errors(stat_errors)
`endif
    );

    // Present a command at a negedge, hold until accepted, return at the
    // negedge of the first cycle after acceptance.
    task automatic sendCmd(input logic [2:0] op, input logic [47:0] key,
                           input logic [15:0] data, output bit ok);
        ok = 1'b0;
        cmd_valid = 1'b1; cmd_op = op; cmd_key = key; cmd_data = data;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = '0; cmd_key = '0; cmd_data = '0;
    endtask

    // Acts as the table until rsp_valid. doneAt: req cycle on which done/found
    // is returned (0 = never). errTail: pulse opErr in the cycle after opReq drops.
    task automatic runTxn(input int doneAt, input logic [15:0] doneData, input bit errTail,
                          input logic [47:0] expKey, input logic [1:0] expCode,
                          input logic [47:0] expOpKey, input logic [15:0] expOpData,
                          output int reqCnt, output int opReqCnt, output int cyc,
                          output bit timedOut, output bit stableOk);
        bit prevOpReq = 1'b0;
        reqCnt = 0; opReqCnt = 0; timedOut = 1'b1; stableOk = 1'b1;
        for (cyc = 0; cyc < 200; cyc++) begin
            done = 1'b0; found = 1'b0; result = '0; opErr = 1'b0;
            if (rsp_valid) begin timedOut = 1'b0; break; end
            if (req) begin
                reqCnt++;
                if (search !== expKey) stableOk = 1'b0;
            end
            if (opReq) begin
                opReqCnt++;
                if (opCode !== expCode || opSearch !== expOpKey || opResult !== expOpData)
                    stableOk = 1'b0;
            end
            if (req && reqCnt == doneAt) begin
                done = 1'b1; found = 1'b1; result = doneData;
            end
            if (errTail && prevOpReq && !opReq) opErr = 1'b1;
            prevOpReq = opReq;
            @(negedge clk);
        end
        done = 1'b0; found = 1'b0; result = '0; opErr = 1'b0;
    endtask

    task automatic consumeRsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cmd_valid = 0; cmd_op = 0; cmd_key = 0; cmd_data = 0;
        rdy = 0; opRdy = 0; found = 0; done = 0; result = 0; opErr = 0; rsp_ready = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({cmd_ready, req, opReq, rsp_valid, rsp_found, rsp_err, rsp_timeout} !== 7'b0) begin
            fails++; $display("FAIL reset_ctrl: got %b expected 0000000",
                {cmd_ready, req, opReq, rsp_valid, rsp_found, rsp_err, rsp_timeout});
        end
        checks++;
        if ({search, opSearch, opResult, opCode, rsp_data} !== '0) begin
            fails++; $display("FAIL reset_data: got %h expected 0",
                {search, opSearch, opResult, opCode, rsp_data});
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            fails++; $display("FAIL idle_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_lookup_hit();
        bit ok, to, st; int rc, oc, cy;
        rdy = 1'b1;
        sendCmd(3'd0, 48'h0000_0000_00AA, 16'h0, ok);
        runTxn(2, 16'h1234, 0, 48'hAA, 2'b00, 48'h0, 16'h0, rc, oc, cy, to, st);
        checks++;
        if (!ok || to) begin fails++; $display("FAIL hit_timeout: accepted %b timed out %b", ok, to); end
        checks++;
        if (rc != 2 || oc != 0) begin fails++; $display("FAIL hit_req_cycles: got req %0d opReq %0d expected 2/0", rc, oc); end
        checks++;
        if (!st) begin fails++; $display("FAIL hit_search_key: search not stable at 48'hAA"); end
        checks++;
        if ({rsp_found, rsp_err, rsp_timeout, rsp_data} !== {3'b100, 16'h1234}) begin
            fails++; $display("FAIL hit_rsp: got f%b e%b t%b d%h expected f1 e0 t0 d1234",
                rsp_found, rsp_err, rsp_timeout, rsp_data);
        end
        consumeRsp();
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++; $display("FAIL hit_consume: got valid %b ready %b expected 0/1", rsp_valid, cmd_ready);
        end
        rdy = 1'b0;
    endtask

    task automatic test_lookup_miss();
        bit ok, to, st; int rc, oc, cy;
        rdy = 1'b1;
        sendCmd(3'd0, 48'h1234_5678_9ABC, 16'h0, ok);
        runTxn(0, 16'h0, 0, 48'h1234_5678_9ABC, 2'b00, 48'h0, 16'h0, rc, oc, cy, to, st);
        checks++;
        if (!ok || to || rc != 4 || !st) begin
            fails++; $display("FAIL miss_req_cycles: got req %0d stable %b timeout %b expected 4/1/0", rc, st, to);
        end
        checks++;
        if ({rsp_found, rsp_err, rsp_data} !== 18'b0) begin
            fails++; $display("FAIL miss_rsp: got f%b e%b d%h expected f0 e0 d0", rsp_found, rsp_err, rsp_data);
        end
        consumeRsp();
        rdy = 1'b0;
    endtask

    task automatic test_add();
        bit ok, to, st; int rc, oc, cy;
        opRdy = 1'b1;
        sendCmd(3'd1, 48'h5, 16'h77, ok);
        runTxn(0, 16'h0, 0, 48'h0, 2'b00, 48'h5, 16'h77, rc, oc, cy, to, st);
        checks++;
        if (!ok || to || oc != 4 || rc != 0) begin
            fails++; $display("FAIL add_opreq_cycles: got opReq %0d req %0d expected 4/0", oc, rc);
        end
        checks++;
        if (!st) begin fails++; $display("FAIL add_op_fields: opCode/opSearch/opResult not 00/5/77"); end
        checks++;
        if ({rsp_found, rsp_err, rsp_timeout, rsp_data} !== 19'b0) begin
            fails++; $display("FAIL add_rsp: got f%b e%b t%b d%h expected all 0",
                rsp_found, rsp_err, rsp_timeout, rsp_data);
        end
        consumeRsp();
        opRdy = 1'b0;
    endtask

    task automatic test_delete_err();
        bit ok, to, st; int rc, oc, cy;
        opRdy = 1'b1;
        sendCmd(3'd2, 48'hABC, 16'h99, ok);
        runTxn(0, 16'h0, 1, 48'h0, 2'b01, 48'hABC, 16'h99, rc, oc, cy, to, st);
        checks++;
        if (!ok || to || oc != 4 || !st) begin
            fails++; $display("FAIL del_opreq: got opReq %0d stable %b expected 4/1", oc, st);
        end
        checks++;
        if ({rsp_err, rsp_timeout} !== 2'b10) begin
            fails++; $display("FAIL del_err_tail: got e%b t%b expected e1 t0", rsp_err, rsp_timeout);
        end
        consumeRsp();
        sendCmd(3'd4, 48'hFFFF, 16'hFFFF, ok);
        runTxn(0, 16'h0, 0, 48'h0, 2'b11, 48'h0, 16'h0, rc, oc, cy, to, st);
        checks++;
        if (!ok || to || oc != 4 || !st || rsp_err !== 1'b0) begin
            fails++; $display("FAIL clear_fields: got opReq %0d stable %b err %b expected 4/1/0", oc, st, rsp_err);
        end
        consumeRsp();
        opRdy = 1'b0;
    endtask

    task automatic test_grant_timeout();
        bit ok, to, st; int rc, oc, cy;
        rdy = 1'b0;
        sendCmd(3'd0, 48'h42, 16'h0, ok);
        runTxn(1, 16'h0, 0, 48'h42, 2'b00, 48'h0, 16'h0, rc, oc, cy, to, st);
        checks++;
        if (!ok || to || cy != 64) begin
            fails++; $display("FAIL timeout_cycles: got %0d expected 64", cy);
        end
        checks++;
        if (rc != 0 || oc != 0) begin
            fails++; $display("FAIL timeout_no_req: got req %0d opReq %0d expected 0/0", rc, oc);
        end
        checks++;
        if ({rsp_err, rsp_timeout, rsp_found} !== 3'b110) begin
            fails++; $display("FAIL timeout_rsp: got e%b t%b f%b expected e1 t1 f0", rsp_err, rsp_timeout, rsp_found);
        end
        consumeRsp();
    endtask

    task automatic test_illegal_hold();
        bit ok, held;
        sendCmd(3'd6, 48'h1, 16'h1, ok);
        checks++;
        if (!ok || {rsp_valid, rsp_err, rsp_timeout, req, opReq} !== 5'b11000) begin
            fails++; $display("FAIL illegal_rsp: got v%b e%b t%b req%b op%b expected v1 e1 t0 0 0",
                rsp_valid, rsp_err, rsp_timeout, req, opReq);
        end
        held = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if ({rsp_valid, rsp_err, rsp_timeout, rsp_found, rsp_data} !== {4'b1100, 16'h0}) held = 1'b0;
        end
        checks++;
        if (!held) begin fails++; $display("FAIL illegal_hold: rsp fields changed while rsp_ready=0"); end
        consumeRsp();
    endtask

    task automatic test_async_reset();
        bit ok;
        rdy = 1'b1;
        sendCmd(3'd0, 48'h77, 16'h0, ok);
        @(negedge clk);
        checks++;
        if (req !== 1'b1) begin fails++; $display("FAIL areset_pre_req: got %b expected 1", req); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({req, opReq, cmd_ready, rsp_valid, search} !== '0) begin
            fails++; $display("FAIL areset_req: got req%b op%b rdy%b v%b s%h expected all 0",
                req, opReq, cmd_ready, rsp_valid, search);
        end
        @(negedge clk); reset = 1'b1; rdy = 1'b0;
        @(negedge clk);
        opRdy = 1'b1;
        sendCmd(3'd3, 48'h9, 16'h9, ok);
        @(negedge clk);
        checks++;
        if (opReq !== 1'b1) begin fails++; $display("FAIL areset_pre_op: got %b expected 1", opReq); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({req, opReq, opCode, opSearch, opResult} !== '0) begin
            fails++; $display("FAIL areset_op: got op%b code%b expected 0", opReq, opCode);
        end
        @(negedge clk); reset = 1'b1; opRdy = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin fails++; $display("FAIL areset_recover: got %b expected 1", cmd_ready); end
    endtask

    initial begin
        test_reset();
        test_lookup_hit();
        test_lookup_miss();
        test_add();
        test_delete_err();
        test_grant_timeout();
        test_illegal_hold();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
